bitmask_decoder_16: RTL and testbench
=====================================

Name: bitmask_decoder_16

Overview:
- Inverse of the 16-to-4 leading-one priority encoder used in the bit-sparse operand path.
- Consumes a stream of 4-bit essential-bit positions, one per beat, terminated by a last flag.
- Rebuilds the 16-bit bitmask for each word and presents it, with its popcount, on a valid/ready output for the PE bit-serial datapath.
- Position encoding matches the encoder: pos 0 = bit 15 (MSB) … pos 15 = bit 0.

Parameters:
- WIDTH, 16, mask width; fixed at 16 for this revision.
- IDX_W, 4, position width; equals log2(WIDTH).
- CNT_W, 5, popcount width; equals IDX_W+1.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid && in_ready
- in_pos  input  IDX_W  encoded bit position; bit set = WIDTH-1-in_pos
- in_zero  input  1  beat carries no bit (encoder is_zero); in_pos ignored
- in_last  input  1  final beat of current word
- out_valid  output  1  reconstructed word available
- out_ready  input  1  downstream accepts word when out_valid && out_ready
- out_mask  output  WIDTH  reconstructed bitmask
- out_cnt  output  CNT_W  popcount of out_mask (0..16)
- out_err  output  1  duplicate-position flag (macro-dependent, see Optional Feature)

Behaviour:
- Reset (reset=1 at posedge clk): acc=0, state=S_IDLE, out_valid=0, out_mask=0, out_cnt=0, out_err=0. Any partial word is discarded. Reset overrides all other events in the same cycle.
- Internal accumulator acc[WIDTH-1:0]; FSM states:
  - S_IDLE: acc==0, no beats of current word accepted.
  - S_ACC: at least one non-last beat accepted.
- Accepted beat, in_zero=0: acc_next = acc | (1 << (WIDTH-1-in_pos)).
- Accepted beat, in_zero=1: acc_next = acc.
- Accepted beat, in_last=0: acc <= acc_next; state -> S_ACC.
- Accepted beat, in_last=1:
  - out_mask <= acc_next; out_cnt <= popcount(acc_next); out_valid <= 1.
  - acc <= 0; state -> S_IDLE.
- Latency: word visible on out_* one cycle after its last beat is accepted.
- Output register: out_mask/out_cnt/out_err hold stable while out_valid && !out_ready.
  - out_valid clears on handshake unless a new last beat loads in the same cycle; the load wins, so out_valid stays 1 with new data.
- in_ready = !(in_last && out_valid && !out_ready).
  - Non-last beats always accepted.
  - A last beat stalls only while the output register holds an unconsumed word.
  - in_ready is combinational from in_last/out_valid/out_ready; no path from in_valid.
- Single-beat word (first beat has in_last=1) is legal. From S_IDLE it yields the one-hot mask, or 0 if in_zero.
- Zero word: single beat with in_zero=1, in_last=1 → out_mask=0, out_cnt=0.
- Duplicate position within a word: OR semantics, bit set once; out_cnt counts distinct bits.
- Back-to-back words: a last beat may be accepted every cycle with out_ready=1, giving full throughput.
- in_valid=0: no state change except output handshake.

Optional Feature:
- Macro: BITMASK_DUP_CHECK_EN.
- Defined:
  - Sticky per-word flag dup sets when an accepted non-zero beat targets a bit already set in acc.
  - The last beat's own collision counts toward dup.
  - On the last beat, out_err <= dup | collision; dup clears with acc.
  - out_err holds with out_mask under the same rules.
- Undefined: dup logic absent; out_err tied to 0.

Test Plan:
- Reset mid-word: beats pos 2, pos 5, then reset=1 for one cycle, then pos 0 with last → out_mask=16'h8000, out_cnt=1.
- Multi-beat word: pos 0, 3, 15 (last on 15), out_ready=1 → one cycle later out_valid=1, out_mask=16'h9001, out_cnt=3.
- Zero word: in_zero=1, in_last=1 → out_mask=16'h0000, out_cnt=0, out_valid=1.
- Backpressure: word A = pos 1 last; out_ready=0; word B = pos 4, pos 7 last.
  - in_ready=0 when B's last is presented; out_mask stays 16'h4000.
  - After out_ready=1, B accepted; next out_mask=16'h0900, out_cnt=2.
- Throughput: 8 single-beat words pos 0..7 on consecutive cycles, out_ready=1 → 8 consecutive out_valid cycles, masks 16'h8000 down to 16'h0100, in_ready constantly 1.
- Duplicate (BITMASK_DUP_CHECK_EN defined): pos 6, pos 6 last → out_mask=16'h0200, out_cnt=1, out_err=1. Without the macro, out_err=0.

Source files
------------

// File: rtl/bitmask_decoder_16_if.sv
// Stream interface for bitmask_decoder_16: position beats in, reconstructed mask words out.
interface bitmask_decoder_16_if #(
   parameter int WIDTH = 16,
   parameter int IDX_W = 4,
   parameter int CNT_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [IDX_W-1:0] in_pos;
   logic             in_zero;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_mask;
   logic [CNT_W-1:0] out_cnt;
   logic             out_err;

   modport master (
      output in_valid, in_pos, in_zero, in_last, out_ready,
      input  in_ready, out_valid, out_mask, out_cnt, out_err
   );

   modport slave (
      input  in_valid, in_pos, in_zero, in_last, out_ready,
      output in_ready, out_valid, out_mask, out_cnt, out_err
   );
endinterface

// File: rtl/bitmask_decoder_16.sv
// Rebuilds 16-bit bitmasks from a stream of leading-one positions (pos 0 = bit 15).
// Optional duplicate-position detection on out_err: define BITMASK_DUP_CHECK_EN.
module bitmask_decoder_16 #(
   parameter int WIDTH = 16,
   parameter int IDX_W = 4,
   parameter int CNT_W = 5
) (
   input logic                 clk,
   input logic                 reset,
   bitmask_decoder_16_if.slave bus
);

   typedef enum logic {S_IDLE, S_ACC} state_t;

   state_t           state;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_base;
   logic [WIDTH-1:0] bit_sel;
   logic [WIDTH-1:0] acc_next;
   logic             in_ready;
   logic             accept;
   logic             out_valid_q;
   logic [WIDTH-1:0] out_mask_q;
   logic [CNT_W-1:0] out_cnt_q;

   function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int unsigned i = 0; i < WIDTH; i++) c = c + CNT_W'(v[i]);
      return c;
   endfunction

   // Only a last beat needs the output register, so only it can stall.
   always_comb in_ready = !(bus.in_last && out_valid_q && !bus.out_ready);
   always_comb accept   = bus.in_valid && in_ready;

   always_comb begin
      bit_sel = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (!bus.in_zero && bus.in_pos == IDX_W'(i)) bit_sel[WIDTH-1-i] = 1'b1;
      end
   end

   always_comb acc_base = (state == S_ACC) ? acc : '0;
   always_comb acc_next = acc_base | bit_sel;

`ifdef BITMASK_DUP_CHECK_EN
   logic dup;
   logic out_err_q;
   logic collision;

   always_comb collision = |(acc_base & bit_sel);

   always_ff @(posedge clk) begin
      if (reset) begin
         dup       <= 1'b0;
         out_err_q <= 1'b0;
      end else if (accept) begin
         if (bus.in_last) begin
            out_err_q <= dup | collision;
            dup       <= 1'b0;
         end else begin
            dup <= dup | collision;
         end
      end
   end

   assign bus.out_err = out_err_q;
`else
   assign bus.out_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         acc         <= '0;
         out_valid_q <= 1'b0;
         out_mask_q  <= '0;
         out_cnt_q   <= '0;
      end else begin
         if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
         // A last beat loading in the handshake cycle overrides the clear above.
         if (accept) begin
            if (bus.in_last) begin
               out_mask_q  <= acc_next;
               out_cnt_q   <= popcount(acc_next);
               out_valid_q <= 1'b1;
               acc         <= '0;
               state       <= S_IDLE;
            end else begin
               acc   <= acc_next;
               state <= S_ACC;
            end
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_mask  = out_mask_q;
   assign bus.out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_bitmask_decoder_16.sv
// Self-checking bench for bitmask_decoder_16: table-driven words plus reset, backpressure and throughput sequences.
module tb_bitmask_decoder_16;

`ifdef BITMASK_DUP_CHECK_EN
   localparam logic DUP = 1'b1;
`else
   localparam logic DUP = 1'b0;
`endif

   typedef struct packed {
      logic [15:0] mask;
      logic [4:0]  cnt;
      logic        err;
   } exp_t;

   typedef struct packed {
      logic [4:0]  n;
      logic [63:0] posv;
      logic [15:0] zmask;
      logic [15:0] mask;
      logic [4:0]  cnt;
      logic        err;
   } vec_t;

   logic clk;
   logic reset;
   bitmask_decoder_16_if #(.WIDTH(16), .IDX_W(4), .CNT_W(5)) bus ();

   bitmask_decoder_16 #(.WIDTH(16), .IDX_W(4), .CNT_W(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_vec   = 0;
   int   n_miss  = 0;
   int   stalls  = 0;
   int   run     = 0;
   int   max_run = 0;
   exp_t sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_word", 32'(bus.out_mask), 32'hDEAD);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("out_mask", 32'(bus.out_mask), 32'(e.mask));
            chk("out_cnt",  32'(bus.out_cnt),  32'(e.cnt));
            chk("out_err",  32'(bus.out_err),  32'(e.err));
         end
      end
   end

   always @(negedge clk) begin
      if (bus.out_valid) run = run + 1;
      else run = 0;
      if (run > max_run) max_run = run;
   end

   task automatic send(input logic [3:0] pos, input logic zero, input logic last,
                       input logic [15:0] m, input logic [4:0] c, input logic e);
      int w;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.in_pos   = pos;
      bus.in_zero  = zero;
      bus.in_last  = last;
      w = 0;
      forever begin
         @(negedge clk);
         if (bus.in_ready) break;
         w++;
         stalls++;
         if (w > 50) begin
            chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
            break;
         end
      end
      if (last && bus.in_ready) sb.push_back('{mask: m, cnt: c, err: e});
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      repeat (2) @(negedge clk);
   endtask

   vec_t vecs[8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{n: 5'd3,  posv: 64'h0000_0000_0000_0F30, zmask: 16'h0000, mask: 16'h9001, cnt: 5'd3,  err: 1'b0};
      vecs[1] = '{n: 5'd1,  posv: 64'h0000_0000_0000_0007, zmask: 16'h0001, mask: 16'h0000, cnt: 5'd0,  err: 1'b0};
      vecs[2] = '{n: 5'd2,  posv: 64'h0000_0000_0000_0066, zmask: 16'h0000, mask: 16'h0200, cnt: 5'd1,  err: DUP};
      vecs[3] = '{n: 5'd2,  posv: 64'h0000_0000_0000_0080, zmask: 16'h0001, mask: 16'h0080, cnt: 5'd1,  err: 1'b0};
      vecs[4] = '{n: 5'd16, posv: 64'hFEDC_BA98_7654_3210, zmask: 16'h0000, mask: 16'hFFFF, cnt: 5'd16, err: 1'b0};
      vecs[5] = '{n: 5'd3,  posv: 64'h0000_0000_0000_03C3, zmask: 16'h0000, mask: 16'h1008, cnt: 5'd2,  err: DUP};
      vecs[6] = '{n: 5'd3,  posv: 64'h0000_0000_0000_0099, zmask: 16'h0004, mask: 16'h0040, cnt: 5'd1,  err: DUP};
      vecs[7] = '{n: 5'd1,  posv: 64'h0000_0000_0000_000F, zmask: 16'h0000, mask: 16'h0001, cnt: 5'd1,  err: 1'b0};

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_pos    = '0;
      bus.in_zero   = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_mask",  32'(bus.out_mask),  32'd0);
      chk("rst_out_cnt",   32'(bus.out_cnt),   32'd0);
      chk("rst_out_err",   32'(bus.out_err),   32'd0);

      // Partial word discarded by reset.
      send(4'd2, 1'b0, 1'b0, '0, '0, 1'b0);
      send(4'd5, 1'b0, 1'b0, '0, '0, 1'b0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      reset        = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      send(4'd0, 1'b0, 1'b1, 16'h8000, 5'd1, 1'b0);
      idle();
      drain();

      foreach (vecs[v]) begin
         for (int b = 0; b < int'(vecs[v].n); b++) begin
            send(vecs[v].posv[4*b +: 4], vecs[v].zmask[b], (b == int'(vecs[v].n) - 1),
                 vecs[v].mask, vecs[v].cnt, vecs[v].err);
         end
      end
      idle();
      drain();

      // Backpressure: word B's last beat must wait for word A to be taken.
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      send(4'd1, 1'b0, 1'b1, 16'h4000, 5'd1, 1'b0);
      send(4'd4, 1'b0, 1'b0, '0, '0, 1'b0);
      @(posedge clk);
      #1;
      bus.in_pos  = 4'd7;
      bus.in_last = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
         chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_out_mask",  32'(bus.out_mask),  32'h4000);
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
      sb.push_back('{mask: 16'h0900, cnt: 5'd2, err: 1'b0});
      idle();
      drain();

      // Full throughput: one single-beat word per cycle.
      stalls  = 0;
      max_run = 0;
      for (int p = 0; p < 8; p++) begin
         logic [15:0] m;
         m = 16'h8000 >> p;
         send(4'(p), 1'b0, 1'b1, m, 5'd1, 1'b0);
      end
      idle();
      drain();
      chk("tp_stalls",    32'(stalls),  32'd0);
      chk("tp_valid_run", 32'(max_run), 32'd8);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
